// File: rtl/ahbl_pkg.sv
// Shared AHB-Lite encodings and helpers.
// Used by the SRAM responder and its write buffer.
package ahbl_pkg;

    typedef enum logic [1:0] {
        HT_IDLE   = 2'b00,
        HT_BUSY   = 2'b01,
        HT_NONSEQ = 2'b10,
        HT_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [2:0] {
        HS_BYTE = 3'd0,
        HS_HALF = 3'd1,
        HS_WORD = 3'd2
    } hsize_e;

    localparam logic HRESP_OKAY = 1'b0;

    // Sizes above word are handled as full-word accesses.
    function automatic logic [3:0] byte_lanes(
        input logic [2:0] hsize,
        input logic [1:0] a
    );
        logic [3:0] l;
        if (hsize == HS_BYTE)
            l = 4'b0001 << a;
        else if (hsize == HS_HALF)
            l = 4'b0011 << {a[1], 1'b0};
        else
            l = 4'hF;
        return l;
    endfunction

endpackage

// File: rtl/ahbl_sram_responder_if.sv
// AHB-Lite slave-side bus bundle.
// The master modport is the bus side; the slave modport is the responder.
interface ahbl_sram_responder_if;

    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic        HREADYOUT;
    logic        HRESP;
    logic [31:0] HRDATA;

    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
        input  HREADYOUT, HRESP, HRDATA
    );

    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
        output HREADYOUT, HRESP, HRDATA
    );

endinterface

// File: rtl/ahbl_wbuf.sv
// One-entry posted write buffer with byte-lane read merge.
// A load in the same cycle as a drain keeps the entry valid.
module ahbl_wbuf
    import ahbl_pkg::*;
#(
    parameter int AW = 14
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          load_i,
    input  logic          drain_i,
    input  logic [AW-3:0] ld_addr_i,
    input  logic [3:0]    ld_lanes_i,
    input  logic [31:0]   ld_data_i,
    input  logic [AW-3:0] rd_addr_i,
    input  logic [31:0]   sram_word_i,
    output logic          valid_o,
    output logic [AW-3:0] addr_o,
    output logic [3:0]    lanes_o,
    output logic [31:0]   data_o,
    output logic [31:0]   merge_o
);

    logic          valid_q, valid_d;
    logic [AW-3:0] addr_q, addr_d;
    logic [3:0]    lanes_q, lanes_d;
    logic [31:0]   data_q, data_d;
    logic          hit;

    always_comb begin
        valid_d = valid_q;
        addr_d  = addr_q;
        lanes_d = lanes_q;
        data_d  = data_q;
        if (load_i) begin
            valid_d = 1'b1;
            addr_d  = ld_addr_i;
            lanes_d = ld_lanes_i;
            data_d  = ld_data_i;
        end else if (drain_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            addr_q  <= '0;
            lanes_q <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            addr_q  <= addr_d;
            lanes_q <= lanes_d;
            data_q  <= data_d;
        end
    end

    assign hit = valid_q && (addr_q == rd_addr_i);

    always_comb begin
        merge_o = sram_word_i;
        for (int b = 0; b < 4; b++) begin
            if (hit && lanes_q[b])
                merge_o[8*b +: 8] = data_q[8*b +: 8];
        end
    end

    assign valid_o = valid_q;
    assign addr_o  = addr_q;
    assign lanes_o = lanes_q;
    assign data_o  = data_q;

endmodule

// File: rtl/ahbl_sram_responder.sv
// Zero-wait AHB-Lite responder in front of a single-port synchronous SRAM.
// Reads own the SRAM port; posted writes drain in any non-read cycle.
module ahbl_sram_responder
    import ahbl_pkg::*;
#(
    parameter int AW = 14
) (
    input  logic                 HCLK,
    input  logic                 HRESET,
    ahbl_sram_responder_if.slave ahb,
    input  logic [31:0]          SRAMRDATA,
    output logic [AW-3:0]        SRAMADDR,
    output logic [31:0]          SRAMWDATA,
    output logic [3:0]           SRAMWEN,
    output logic                 SRAMCS
);

    logic          req, rd_req, wr_req;
    logic          rd_active_q, rd_active_d;
    logic [AW-3:0] rd_addr_q, rd_addr_d;
    logic          wr_active_q, wr_active_d;
    logic [AW-3:0] wr_addr_q, wr_addr_d;
    logic [3:0]    wr_lanes_q, wr_lanes_d;

    logic          buf_valid;
    logic [AW-3:0] buf_addr;
    logic [3:0]    buf_lanes;
    logic [31:0]   buf_data;
    logic [31:0]   merged;
    logic          drain;
    logic          unused_haddr;

    assign unused_haddr = ^ahb.HADDR[31:AW];

    assign req    = ahb.HSEL & ahb.HREADY & ahb.HTRANS[1];
    assign rd_req = req & ~ahb.HWRITE;
    assign wr_req = req & ahb.HWRITE;
    assign drain  = buf_valid & ~rd_req;

    always_comb begin
        rd_active_d = rd_req;
        rd_addr_d   = rd_addr_q;
        wr_active_d = wr_req;
        wr_addr_d   = wr_addr_q;
        wr_lanes_d  = wr_lanes_q;
        if (rd_req)
            rd_addr_d = ahb.HADDR[AW-1:2];
        if (wr_req) begin
            wr_addr_d  = ahb.HADDR[AW-1:2];
            wr_lanes_d = byte_lanes(ahb.HSIZE, ahb.HADDR[1:0]);
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            rd_active_q <= 1'b0;
            rd_addr_q   <= '0;
            wr_active_q <= 1'b0;
            wr_addr_q   <= '0;
            wr_lanes_q  <= '0;
        end else begin
            rd_active_q <= rd_active_d;
            rd_addr_q   <= rd_addr_d;
            wr_active_q <= wr_active_d;
            wr_addr_q   <= wr_addr_d;
            wr_lanes_q  <= wr_lanes_d;
        end
    end

    ahbl_wbuf #(
        .AW (AW)
    ) u_wbuf (
        .clk_i       (HCLK),
        .rst_i       (HRESET),
        .load_i      (wr_active_q),
        .drain_i     (drain),
        .ld_addr_i   (wr_addr_q),
        .ld_lanes_i  (wr_lanes_q),
        .ld_data_i   (ahb.HWDATA),
        .rd_addr_i   (rd_addr_q),
        .sram_word_i (SRAMRDATA),
        .valid_o     (buf_valid),
        .addr_o      (buf_addr),
        .lanes_o     (buf_lanes),
        .data_o      (buf_data),
        .merge_o     (merged)
    );

    // Read address phase wins the port; the buffer simply waits.
    always_comb begin
        SRAMCS    = 1'b0;
        SRAMWEN   = 4'h0;
        SRAMADDR  = '0;
        SRAMWDATA = '0;
        if (!HRESET) begin
            if (rd_req) begin
                SRAMCS   = 1'b1;
                SRAMADDR = ahb.HADDR[AW-1:2];
            end else if (buf_valid) begin
                SRAMCS    = 1'b1;
                SRAMADDR  = buf_addr;
                SRAMWEN   = buf_lanes;
                SRAMWDATA = buf_data;
            end
        end
    end

    assign ahb.HRDATA    = (rd_active_q && !HRESET) ? merged : 32'h0;
    assign ahb.HREADYOUT = 1'b1;
    assign ahb.HRESP     = HRESP_OKAY;

endmodule

// File: tb/tb_ahbl_sram_responder.sv
// Directed-vector bench for the AHB-Lite SRAM responder with an SRAM model.
module tb_ahbl_sram_responder;
    import ahbl_pkg::*;

    localparam logic [1:0] NS = 2'b10;
    localparam logic [1:0] SQ = 2'b11;
    localparam logic [1:0] ID = 2'b00;
    localparam logic [1:0] BS = 2'b01;
    localparam logic [2:0] SB = 3'd0;
    localparam logic [2:0] SH = 3'd1;
    localparam logic [2:0] SW = 3'd2;

    logic        clk = 1'b0;
    logic        rst;
    logic        preload;
    logic [31:0] sram_rdata;
    logic [11:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [3:0]  sram_wen;
    logic        sram_cs;
    logic [31:0] mem [0:4095];
    int          wen_pulses = 0;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    ahbl_sram_responder_if bus();

    ahbl_sram_responder #(.AW(14)) dut (
        .HCLK      (clk),
        .HRESET    (rst),
        .ahb       (bus.slave),
        .SRAMRDATA (sram_rdata),
        .SRAMADDR  (sram_addr),
        .SRAMWDATA (sram_wdata),
        .SRAMWEN   (sram_wen),
        .SRAMCS    (sram_cs)
    );

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 4096; i++)
                mem[i] <= {16'hC0DE, i[15:0]};
            sram_rdata <= 32'h0;
        end else if (sram_cs) begin
            if (sram_wen != 4'h0) begin
                for (int b = 0; b < 4; b++)
                    if (sram_wen[b])
                        mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
                wen_pulses <= wen_pulses + 1;
            end else begin
                sram_rdata <= mem[sram_addr];
            end
        end
    end

    typedef struct {
        logic        sel;
        logic [1:0]  trans;
        logic        wr;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        hrdy;
        logic        cs;
        logic [3:0]  wen;
        logic [11:0] saddr;
        logic [31:0] swdata;
        logic [31:0] hrdata;
    } vec_t;

    vec_t vq[$];

    function automatic void add(
        input logic sel, input logic [1:0] trans, input logic wr,
        input logic [2:0] size, input logic [31:0] addr,
        input logic [31:0] wdata, input logic hrdy,
        input logic cs, input logic [3:0] wen, input logic [11:0] saddr,
        input logic [31:0] swdata, input logic [31:0] hrdata
    );
        vec_t v;
        v.sel = sel; v.trans = trans; v.wr = wr; v.size = size;
        v.addr = addr; v.wdata = wdata; v.hrdy = hrdy;
        v.cs = cs; v.wen = wen; v.saddr = saddr;
        v.swdata = swdata; v.hrdata = hrdata;
        vq.push_back(v);
    endfunction

    task automatic chk(input string nm, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] got=%h exp=%h", nm, idx, act, exp);
        end
    endtask

    task automatic drive(input logic sel, input logic [1:0] trans,
                         input logic wr, input logic [2:0] size,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic hrdy);
        bus.HSEL   = sel;
        bus.HTRANS = trans;
        bus.HWRITE = wr;
        bus.HSIZE  = size;
        bus.HADDR  = addr;
        bus.HWDATA = wdata;
        bus.HREADY = hrdy;
    endtask

    task automatic chk_outs(input int idx, input logic cs,
                            input logic [3:0] wen, input logic [11:0] sa,
                            input logic [31:0] swd, input logic [31:0] hr);
        chk("cs", idx, {31'b0, sram_cs}, {31'b0, cs});
        chk("wen", idx, {28'b0, sram_wen}, {28'b0, wen});
        chk("saddr", idx, {20'b0, sram_addr}, {20'b0, sa});
        chk("swdata", idx, sram_wdata, swd);
        chk("hrdata", idx, bus.HRDATA, hr);
        chk("hreadyout", idx, {31'b0, bus.HREADYOUT}, 32'd1);
        chk("hresp", idx, {31'b0, bus.HRESP}, 32'd0);
    endtask

    int pulses_at_rst;

    initial begin
        // Word write then read back
        add(1,NS,1,SW,'h100,0,1,          0,0,0,0,0);
        add(0,ID,0,SW,0,'hDEADBEEF,1,     0,0,0,0,0);
        add(0,ID,0,SW,0,0,1,              1,'hF,'h40,'hDEADBEEF,0);
        add(1,NS,0,SW,'h100,0,1,          1,0,'h40,0,0);
        add(0,ID,0,SW,0,0,1,              0,0,0,0,'hDEADBEEF);
        // Byte write, read right behind it merges the new byte
        add(1,NS,1,SW,'h100,0,1,          0,0,0,0,0);
        add(0,ID,0,SW,0,'h11223344,1,     0,0,0,0,0);
        add(0,ID,0,SW,0,0,1,              1,'hF,'h40,'h11223344,0);
        add(1,NS,1,SB,'h101,0,1,          0,0,0,0,0);
        add(1,NS,0,SW,'h100,'h0000AA00,1, 1,0,'h40,0,0);
        add(0,ID,0,SW,0,0,1,              1,'h2,'h40,'h0000AA00,'h1122AA44);
        add(1,NS,0,SW,'h100,0,1,          1,0,'h40,0,0);
        add(0,ID,0,SW,0,0,1,              0,0,0,0,'h1122AA44);
        // Half write held off by a read stream
        add(1,NS,1,SH,'h202,0,1,          0,0,0,0,0);
        add(1,NS,0,SW,'h000,'h55660000,1, 1,0,0,0,0);
        add(1,NS,0,SW,'h004,0,1,          1,0,1,0,'hC0DE0000);
        add(1,SQ,0,SW,'h008,0,1,          1,0,2,0,'hC0DE0001);
        add(1,SQ,0,SW,'h200,0,1,          1,0,'h80,0,'hC0DE0002);
        add(0,ID,0,SW,0,0,1,              1,'hC,'h80,'h55660000,'h55660080);
        add(1,NS,0,SW,'h200,0,1,          1,0,'h80,0,0);
        add(0,ID,0,SW,0,0,1,              0,0,0,0,'h55660080);
        // Back-to-back writes drain during the next address phase
        add(1,NS,1,SW,'h0,0,1,            0,0,0,0,0);
        add(1,NS,1,SW,'h4,1,1,            0,0,0,0,0);
        add(1,NS,1,SW,'h8,2,1,            1,'hF,0,1,0);
        add(0,ID,0,SW,0,3,1,              1,'hF,1,2,0);
        add(0,ID,0,SW,0,0,1,              1,'hF,2,3,0);
        add(1,NS,0,SW,'h0,0,1,            1,0,0,0,0);
        add(1,NS,0,SW,'h4,0,1,            1,0,1,0,1);
        add(1,NS,0,SW,'h8,0,1,            1,0,2,0,2);
        add(0,ID,0,SW,0,0,1,              0,0,0,0,3);
        // Non-transfers: BUSY, HREADY low, HSEL low
        add(1,BS,0,SW,'h0,0,1,            0,0,0,0,0);
        add(1,NS,0,SW,'h0,0,0,            0,0,0,0,0);
        add(0,ID,0,SW,0,0,1,              0,0,0,0,0);
        add(1,NS,1,SW,'h0,0,0,            0,0,0,0,0);
        add(0,ID,0,SW,0,'hFFFFFFFF,1,     0,0,0,0,0);
        add(0,ID,0,SW,0,0,1,              0,0,0,0,0);
        add(0,NS,0,SW,'h4,0,1,            0,0,0,0,0);
        add(0,ID,0,SW,0,0,1,              0,0,0,0,0);
        // Oversized HSIZE acts as a word
        add(1,NS,1,3'd5,'h9,0,1,          0,0,0,0,0);
        add(0,ID,0,SW,0,'hCAFEF00D,1,     0,0,0,0,0);
        add(0,ID,0,SW,0,0,1,              1,'hF,2,'hCAFEF00D,0);
        add(1,SQ,0,SW,'h4,0,1,            1,0,1,0,0);
        add(0,ID,0,SW,0,0,1,              0,0,0,0,2);

        rst = 1'b1;
        preload = 1'b1;
        drive(0, ID, 0, SW, 0, 0, 1);
        repeat (2) @(negedge clk);
        preload = 1'b0;
        #3;
        chk_outs(-1, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        #3;
        chk_outs(-2, 0, 0, 0, 0, 0);

        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk);
            drive(vq[i].sel, vq[i].trans, vq[i].wr, vq[i].size,
                  vq[i].addr, vq[i].wdata, vq[i].hrdy);
            #3;
            chk_outs(i, vq[i].cs, vq[i].wen, vq[i].saddr,
                     vq[i].swdata, vq[i].hrdata);
        end

        // Reset right after a write data phase discards the buffer
        @(negedge clk);
        drive(1, NS, 1, SW, 'h0, 0, 1);
        @(negedge clk);
        drive(0, ID, 0, SW, 0, 'h12345678, 1);
        @(negedge clk);
        rst = 1'b1;
        drive(0, ID, 0, SW, 0, 0, 1);
        #3;
        pulses_at_rst = wen_pulses;
        chk_outs(100, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        #3;
        chk_outs(101, 0, 0, 0, 0, 0);
        @(negedge clk);
        #3;
        chk_outs(102, 0, 0, 0, 0, 0);
        @(negedge clk);
        drive(1, NS, 0, SW, 'h0, 0, 1);
        #3;
        chk_outs(103, 1, 0, 0, 0, 0);
        @(negedge clk);
        drive(0, ID, 0, SW, 0, 0, 1);
        #3;
        chk_outs(104, 0, 0, 0, 0, 1);
        chk("rst_no_wen", 105, wen_pulses, pulses_at_rst);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
